// File: rtl/ppu_mode_sequencer.sv
// Per-dot PPU scheduler: walks dot/line position through OAM scan, draw, HBLANK and VBLANK,
// launches the scan/draw blocks and drives LY, STAT mode, CPU lockouts and interrupt pulses.
module ppu_mode_sequencer #(
    parameter int unsigned DOTS_PER_LINE   = 456,
    parameter int unsigned LINES_PER_FRAME = 154,
    parameter int unsigned VISIBLE_LINES   = 144,
    parameter int unsigned OAM_SCAN_DOTS   = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_en,
    input  logic       mode3_done,
    input  logic [7:0] LYC,
    input  logic [3:0] STAT_en,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic [1:0] mode,
    output logic       lyc_match,
    output logic       oam_scan_start,
    output logic       mode3_start,
    output logic       frame_start,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       draw_overrun,
    output logic       oam_lock,
    output logic       vram_lock
);

    localparam logic [8:0] DotLast   = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OamLast   = 9'(OAM_SCAN_DOTS - 1);
    localparam logic [7:0] LyLast    = 8'(LINES_PER_FRAME - 1);
    localparam logic [7:0] LyVisLast = 8'(VISIBLE_LINES - 1);
    localparam logic [7:0] LyVblank  = 8'(VISIBLE_LINES);

    typedef enum logic [2:0] {
        StOff,
        StOamScan,
        StDraw,
        StHblank,
        StVblank
    } state_e;

    state_e     state_q, state_d;
    logic [8:0] dot_q, dot_d;
    logic [7:0] ly_q, ly_d;
    logic [1:0] mode_q, mode_d;
    logic       stat_line_q, stat_line_d;
    logic       oam_scan_start_q, oam_scan_start_d;
    logic       mode3_start_q, mode3_start_d;
    logic       frame_start_q, frame_start_d;
    logic       vblank_irq_q, vblank_irq_d;
    logic       stat_irq_q, stat_irq_d;
    logic       draw_overrun_q, draw_overrun_d;
    logic       oam_lock_q, oam_lock_d;
    logic       vram_lock_q, vram_lock_d;

    logic       at_line_end;
    logic       visible_line_end;
    logic       lyc_next;

    always_comb begin
        state_d          = state_q;
        dot_d            = dot_q;
        ly_d             = ly_q;
        oam_scan_start_d = 1'b0;
        mode3_start_d    = 1'b0;
        frame_start_d    = 1'b0;
        vblank_irq_d     = 1'b0;
        draw_overrun_d   = 1'b0;
        at_line_end      = (dot_q == DotLast);
        visible_line_end = 1'b0;

        if (!lcd_en) begin
            // Disabling the LCD abandons whatever is in flight, including a draw.
            state_d = StOff;
            dot_d   = '0;
            ly_d    = '0;
        end else if (state_q == StOff) begin
            state_d          = StOamScan;
            dot_d            = '0;
            ly_d             = '0;
            oam_scan_start_d = 1'b1;
            frame_start_d    = 1'b1;
        end else begin
            dot_d = at_line_end ? '0 : dot_q + 9'd1;
            case (state_q)
                StOamScan: begin
                    if (dot_q == OamLast) begin
                        state_d       = StDraw;
                        mode3_start_d = 1'b1;
                    end
                end
                StDraw: begin
                    if (mode3_done) begin
                        state_d          = StHblank;
                        visible_line_end = at_line_end;
                    end else if (at_line_end) begin
                        draw_overrun_d   = 1'b1;
                        visible_line_end = 1'b1;
                    end
                end
                StHblank: visible_line_end = at_line_end;
                StVblank: begin
                    if (at_line_end) begin
                        if (ly_q == LyLast) begin
                            state_d          = StOamScan;
                            ly_d             = '0;
                            oam_scan_start_d = 1'b1;
                            frame_start_d    = 1'b1;
                        end else begin
                            ly_d = ly_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase

            if (visible_line_end) begin
                if (ly_q == LyVisLast) begin
                    state_d      = StVblank;
                    ly_d         = LyVblank;
                    vblank_irq_d = 1'b1;
                end else begin
                    state_d          = StOamScan;
                    ly_d             = ly_q + 8'd1;
                    oam_scan_start_d = 1'b1;
                end
            end
        end

        case (state_d)
            StOamScan: mode_d = 2'd2;
            StDraw:    mode_d = 2'd3;
            StVblank:  mode_d = 2'd1;
            default:   mode_d = 2'd0;
        endcase

        oam_lock_d  = (state_d == StOamScan) || (state_d == StDraw);
        vram_lock_d = (state_d == StDraw);

        // STAT sources are judged on the values that become visible next cycle.
        lyc_next    = (state_d != StOff) && (ly_d == LYC);
        stat_line_d = (state_d != StOff) &&
                      ((STAT_en[0] && (mode_d == 2'd0)) ||
                       (STAT_en[1] && (mode_d == 2'd1)) ||
                       (STAT_en[2] && (mode_d == 2'd2)) ||
                       (STAT_en[3] && lyc_next));
        stat_irq_d  = stat_line_d && !stat_line_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StOff;
            dot_q            <= '0;
            ly_q             <= '0;
            mode_q           <= '0;
            stat_line_q      <= 1'b0;
            oam_scan_start_q <= 1'b0;
            mode3_start_q    <= 1'b0;
            frame_start_q    <= 1'b0;
            vblank_irq_q     <= 1'b0;
            stat_irq_q       <= 1'b0;
            draw_overrun_q   <= 1'b0;
            oam_lock_q       <= 1'b0;
            vram_lock_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            dot_q            <= dot_d;
            ly_q             <= ly_d;
            mode_q           <= mode_d;
            stat_line_q      <= stat_line_d;
            oam_scan_start_q <= oam_scan_start_d;
            mode3_start_q    <= mode3_start_d;
            frame_start_q    <= frame_start_d;
            vblank_irq_q     <= vblank_irq_d;
            stat_irq_q       <= stat_irq_d;
            draw_overrun_q   <= draw_overrun_d;
            oam_lock_q       <= oam_lock_d;
            vram_lock_q      <= vram_lock_d;
        end
    end

    assign ly             = ly_q;
    assign dot            = dot_q;
    assign mode           = mode_q;
    assign lyc_match      = (state_q != StOff) && (ly_q == LYC);
    assign oam_scan_start = oam_scan_start_q;
    assign mode3_start    = mode3_start_q;
    assign frame_start    = frame_start_q;
    assign vblank_irq     = vblank_irq_q;
    assign stat_irq       = stat_irq_q;
    assign draw_overrun   = draw_overrun_q;
    assign oam_lock       = oam_lock_q;
    assign vram_lock      = vram_lock_q;

endmodule

// File: tb/tb_ppu_mode_sequencer.sv
// Bench for ppu_mode_sequencer: a position/arithmetic model checked every cycle, plus
// directed literal checks at key dots of a frame, an LCD-off episode and an async reset.
module tb_ppu_mode_sequencer;

    localparam int DOTS  = 456;
    localparam int LINES = 154;
    localparam int VIS   = 144;
    localparam int OAM   = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_en = 1'b0;
    logic       mode3_done;
    logic [7:0] LYC = 8'd5;
    logic [3:0] STAT_en = 4'b1000;

    logic [7:0] ly;
    logic [8:0] dot;
    logic [1:0] mode;
    logic       lyc_match, oam_scan_start, mode3_start, frame_start;
    logic       vblank_irq, stat_irq, draw_overrun, oam_lock, vram_lock;

    ppu_mode_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lcd_en         (lcd_en),
        .mode3_done     (mode3_done),
        .LYC            (LYC),
        .STAT_en        (STAT_en),
        .ly             (ly),
        .dot            (dot),
        .mode           (mode),
        .lyc_match      (lyc_match),
        .oam_scan_start (oam_scan_start),
        .mode3_start    (mode3_start),
        .frame_start    (frame_start),
        .vblank_irq     (vblank_irq),
        .stat_irq       (stat_irq),
        .draw_overrun   (draw_overrun),
        .oam_lock       (oam_lock),
        .vram_lock      (vram_lock)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: what the visible outputs must be after each edge.
    bit m_on = 0, m_drawn = 0, m_stat = 0;
    int m_ly = 0, m_dot = 0, m_mode = 0;
    bit m_oss = 0, m_fs = 0, m_vb = 0, m_m3s = 0, m_ovr = 0, m_sirq = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit on, drawn, ovr, st;
        int nly, ndot, md;
        if (!rst_n) begin
            m_on <= 0; m_drawn <= 0; m_stat <= 0; m_ly <= 0; m_dot <= 0; m_mode <= 0;
            m_oss <= 0; m_fs <= 0; m_vb <= 0; m_m3s <= 0; m_ovr <= 0; m_sirq <= 0;
        end else begin
            on = m_on; drawn = m_drawn; nly = m_ly; ndot = m_dot; ovr = 0;
            if (!lcd_en) begin
                on = 0; nly = 0; ndot = 0; drawn = 0;
            end else if (!m_on) begin
                on = 1; nly = 0; ndot = 0; drawn = 0;
            end else begin
                if (m_mode == 3 && mode3_done) drawn = 1;
                if (ndot == DOTS - 1) begin
                    ovr   = (m_mode == 3) && !mode3_done;
                    ndot  = 0;
                    nly   = (nly + 1) % LINES;
                    drawn = 0;
                end else begin
                    ndot++;
                end
            end
            md = !on ? 0 : (nly >= VIS) ? 1 : (ndot < OAM) ? 2 : drawn ? 0 : 3;
            st = on && ((STAT_en[0] && md == 0) || (STAT_en[1] && md == 1) ||
                        (STAT_en[2] && md == 2) || (STAT_en[3] && nly == int'(LYC)));
            m_on <= on; m_drawn <= drawn; m_ly <= nly; m_dot <= ndot; m_mode <= md;
            m_oss  <= on && md == 2 && ndot == 0;
            m_fs   <= on && nly == 0 && ndot == 0;
            m_vb   <= on && nly == VIS && ndot == 0;
            m_m3s  <= on && md == 3 && ndot == OAM;
            m_ovr  <= ovr;
            m_sirq <= st && !m_stat;
            m_stat <= st;
        end
    end

    // Draw length 172 from dot 80 (done at 252); line 3 never finishes, line 8 finishes at once,
    // line 2 sees stray done pulses in OAM scan and HBLANK.
    logic inject_done = 1'b0;
    logic auto_done;
    always_comb begin
        auto_done = m_on && ((m_mode == 3 && m_ly != 3 && m_dot == ((m_ly == 8) ? OAM : 252)) ||
                             (m_ly == 2 && (m_dot == 30 || m_dot == 300)));
    end
    assign mode3_done = auto_done | inject_done;

    always @(negedge clk) begin
        check("ly", ly, m_ly);
        check("dot", dot, m_dot);
        check("mode", mode, m_mode);
        check("lyc_match", lyc_match, (m_on && m_ly == int'(LYC)) ? 1 : 0);
        check("oam_scan_start", oam_scan_start, m_oss);
        check("mode3_start", mode3_start, m_m3s);
        check("frame_start", frame_start, m_fs);
        check("vblank_irq", vblank_irq, m_vb);
        check("stat_irq", stat_irq, m_sirq);
        check("draw_overrun", draw_overrun, m_ovr);
        check("oam_lock", oam_lock, (m_mode == 2 || m_mode == 3) ? 1 : 0);
        check("vram_lock", vram_lock, (m_mode == 3) ? 1 : 0);
    end

    task automatic wait_at(input int ly_w, input int dot_w);
        int n = 0;
        while (!(m_on && m_ly == ly_w && m_dot == dot_w) && n < 80000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 80000) begin
            checks++;
            errors++;
            $display("FAIL wait_at: reached=0 required=1 for ly=%0d dot=%0d", ly_w, dot_w);
        end
    endtask

    int t_start;

    initial begin
        repeat (3) @(negedge clk);
        check("reset ly", ly, 0);
        check("reset dot", dot, 0);
        check("reset mode", mode, 0);
        check("reset oam_lock", oam_lock, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("off hold dot", dot, 0);
        check("off lyc_match", lyc_match, 0);

        lcd_en = 1'b1;
        @(negedge clk);
        t_start = cycle;
        check("on dot", dot, 0);
        check("on mode", mode, 2);
        check("on oam_scan_start", oam_scan_start, 1);
        check("on frame_start", frame_start, 1);

        wait_at(0, 79);
        check("dot79 mode", mode, 2);
        @(negedge clk);
        check("dot80 mode3_start", mode3_start, 1);
        check("dot80 mode", mode, 3);
        wait_at(0, 252);
        check("dot252 mode", mode, 3);
        @(negedge clk);
        check("dot253 dot", dot, 253);
        check("dot253 mode", mode, 0);
        check("dot253 vram_lock", vram_lock, 0);
        wait_at(1, 0);
        check("line1 cycles", cycle - t_start, 456);
        check("line1 ly", ly, 1);
        check("line1 mode", mode, 2);

        wait_at(3, 455);
        check("ovr line3 vram_lock", vram_lock, 1);
        check("ovr line3 mode", mode, 3);
        @(negedge clk);
        check("ovr next ly", ly, 4);
        check("ovr next mode", mode, 2);
        check("ovr next oam_scan_start", oam_scan_start, 1);
        check("ovr draw_overrun", draw_overrun, 1);

        wait_at(5, 0);
        check("lyc rise stat_irq", stat_irq, 1);
        check("lyc rise lyc_match", lyc_match, 1);
        STAT_en = 4'b1001;
        wait_at(5, 253);
        check("blocked hblank mode", mode, 0);
        check("blocked hblank stat_irq", stat_irq, 0);
        wait_at(6, 253);
        check("ly6 hblank stat_irq", stat_irq, 1);

        wait_at(8, 80);
        check("short draw mode3_start", mode3_start, 1);
        @(negedge clk);
        check("short draw mode", mode, 0);

        wait_at(144, 0);
        check("vblank vblank_irq", vblank_irq, 1);
        check("vblank mode", mode, 1);
        check("vblank oam_scan_start", oam_scan_start, 0);
        wait_at(153, 455);
        check("ly153 mode", mode, 1);
        @(negedge clk);
        check("wrap ly", ly, 0);
        check("wrap mode", mode, 2);
        check("wrap frame_start", frame_start, 1);
        check("frame period", cycle - t_start, 70224);

        wait_at(7, 120);
        check("drop in draw", mode, 3);
        lcd_en = 1'b0;
        inject_done = 1'b1;
        @(negedge clk);
        check("off mode", mode, 0);
        check("off ly", ly, 0);
        check("off dot", dot, 0);
        check("off oam_lock", oam_lock, 0);
        check("off vram_lock", vram_lock, 0);
        @(negedge clk);
        check("late done dot", dot, 0);
        check("late done mode", mode, 0);
        inject_done = 1'b0;
        lcd_en = 1'b1;
        @(negedge clk);
        check("reen oam_scan_start", oam_scan_start, 1);
        check("reen frame_start", frame_start, 1);

        wait_at(2, 200);
        #2;
        rst_n = 1'b0;
        #1;
        check("async ly", ly, 0);
        check("async dot", dot, 0);
        check("async mode", mode, 0);
        check("async oam_lock", oam_lock, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart dot", dot, 0);
        check("restart frame_start", frame_start, 1);
        check("restart mode", mode, 2);
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppu_mode_sequencer.md
Name: ppu_mode_sequencer

Overview:
- Per-dot scheduler for the PPU. Tracks dot and line position and sequences the PPU through OAM scan, drawing, HBLANK and VBLANK.
- Issues the start pulses that launch the OAM-scan and mode-3 pixel-pipeline blocks and consumes the mode-3 done pulse.
- Drives the CPU-side VRAM/OAM lockouts, the LY register value, the STAT mode bits and the VBLANK/STAT interrupt pulses.

Parameters:
DOTS_PER_LINE, 456, dots per scanline; dot counter wraps at DOTS_PER_LINE-1
LINES_PER_FRAME, 154, lines per frame; ly wraps at LINES_PER_FRAME-1
VISIBLE_LINES, 144, first VBLANK line index
OAM_SCAN_DOTS, 80, dots spent in mode 2

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
lcd_en  in  1  LCDC[7]; low holds the sequencer in OFF
mode3_done  in  1  one-cycle done pulse from the mode-3 pixel pipeline
LYC  in  8  LY compare register
STAT_en  in  4  STAT[6:3] interrupt source enables: {lyc, mode2, mode1, mode0}
ly  out  8  current line (LY register)
dot  out  9  current dot within line
mode  out  2  STAT mode: 0 HBLANK/OFF, 1 VBLANK, 2 OAM scan, 3 draw
lyc_match  out  1  ly == LYC; forced 0 in OFF
oam_scan_start  out  1  one-cycle pulse, first cycle of mode 2
mode3_start  out  1  one-cycle pulse, first cycle of mode 3
frame_start  out  1  one-cycle pulse at ly=0, dot=0
vblank_irq  out  1  one-cycle pulse at ly=VISIBLE_LINES, dot=0
stat_irq  out  1  one-cycle pulse on rising edge of the STAT line
draw_overrun  out  1  one-cycle pulse when a line ends while still in DRAW
oam_lock  out  1  CPU OAM access blocked (mode 2 or 3)
vram_lock  out  1  CPU VRAM access blocked (mode 3)

Behaviour:
- Reset (rst_n low, asynchronous):
  - State OFF; ly=0, dot=0, mode=0.
  - All pulses, locks and lyc_match are 0.
  - The internal stat_line register is 0.
- All outputs are registered except lyc_match, which is combinational from the registered ly, LYC and state.
- States: OFF, OAM_SCAN, DRAW, HBLANK, VBLANK. mode reports 2, 3, 0, 1 respectively; OFF reports 0.
- OFF:
  - dot and ly are held at 0.
  - When lcd_en=1, the next cycle enters OAM_SCAN with ly=0, dot=0, and pulses oam_scan_start and frame_start.
- lcd_en=0 in any state: the next cycle is OFF with ly=0, dot=0, mode=0 and locks released. Any DRAW in progress is abandoned and no pulse fires.
- Outside OFF, dot increments every cycle. At DOTS_PER_LINE-1 it wraps to 0, and ly increments, wrapping from LINES_PER_FRAME-1 to 0.
- OAM_SCAN:
  - At dot=OAM_SCAN_DOTS-1, transition to DRAW.
  - mode3_start pulses in the first DRAW cycle (dot=80).
- DRAW:
  - mode3_done=1 moves to HBLANK the next cycle.
  - mode3_done in the same cycle as mode3_start is legal and gives a 1-cycle DRAW.
- mode3_done in any state other than DRAW is ignored.
- DRAW overrun: if dot=DOTS_PER_LINE-1 and mode3_done=0:
  - draw_overrun pulses.
  - The line-end transition below is taken as if from HBLANK.
- Line end (dot=DOTS_PER_LINE-1, state HBLANK or overrun DRAW):
  - If ly=VISIBLE_LINES-1: go to VBLANK with ly=VISIBLE_LINES and pulse vblank_irq.
  - Otherwise: go to OAM_SCAN with ly+1 and pulse oam_scan_start.
- VBLANK:
  - Line ends increment ly and stay in VBLANK.
  - At ly=LINES_PER_FRAME-1, dot=DOTS_PER_LINE-1: go to OAM_SCAN with ly=0, and pulse oam_scan_start and frame_start.
- Pulses are aligned to the first cycle in which the new state, ly and dot are visible.
- STAT line:
  - stat_line_next = (STAT_en[0]&mode==0) | (STAT_en[1]&mode==1) | (STAT_en[2]&mode==2) | (STAT_en[3]&lyc_match), evaluated on the next-state values.
  - stat_irq = stat_line_next & ~stat_line.
  - stat_line stays high across back-to-back sources (STAT blocking), so there is no second pulse until the line drops.
  - In OFF, stat_line is forced to 0.
- Simultaneous lcd_en fall and mode3_done: OFF wins.

Test Plan:
- rst_n release, lcd_en=1, mode3_done 172 cycles after mode3_start -> oam_scan_start and frame_start at dot 0; mode=2 for dots 0-79; mode3_start at dot 80; mode=3 for dots 80-252; mode=0 from dot 253; ly=1 and mode=2 at cycle 456.
- Run 2 frames with fixed 172-dot draws -> frame_start pulses exactly 70224 cycles apart; vblank_irq at ly=144, dot=0; no oam_scan_start on ly 144-153; ly wraps 153->0.
- mode3_done never asserted on line 3 -> draw_overrun at ly=3, dot=455; next cycle ly=4, mode=2, oam_scan_start=1; vram_lock held 1 through dot 455 of line 3.
- lcd_en dropped at ly=50, dot=120 (DRAW) -> next cycle mode=0, ly=0, dot=0, oam_lock=vram_lock=0; a late mode3_done is ignored; lcd_en re-raised -> oam_scan_start and frame_start the following cycle.
- STAT_en=4'b1001, LYC=5 -> one stat_irq at ly=5, dot=0; no pulse at the HBLANK entry on line 5 (blocked); next pulse at the HBLANK entry on ly=6.
- rst_n pulsed low asynchronously at ly=100 mid-line (no clk edge) -> all outputs 0 immediately; after release with lcd_en=1 -> restart at ly=0, dot=0 with frame_start.
